// File: rtl/duart_pkg.sv
// Shared constants for the DUART CPU bus sequencer: register-select map,
// sequencer states and the wait/recovery counter width.
package duart_pkg;

  localparam int CNT_W = 4;

  localparam logic [3:0] RS_MRA = 4'h0;
  localparam logic [3:0] RS_SRA = 4'h1;
  localparam logic [3:0] RS_CRA = 4'h2;
  localparam logic [3:0] RS_HRA = 4'h3;
  localparam logic [3:0] RS_MRB = 4'h8;
  localparam logic [3:0] RS_SRB = 4'h9;
  localparam logic [3:0] RS_CRB = 4'hA;
  localparam logic [3:0] RS_HRB = 4'hB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STROBE  = 3'd1,
    WAIT    = 3'd2,
    ACK     = 3'd3,
    RECOVER = 3'd4
  } state_e;

  // One-hot strobe vector: [3:0] = channel A MR/SR/CR/HR, [7:4] = channel B.
  function automatic logic [7:0] rs_decode(input logic [3:0] a);
    logic [7:0] oh;
    oh = '0;
    unique case (a)
      RS_MRA:  oh = 8'h01;
      RS_SRA:  oh = 8'h02;
      RS_CRA:  oh = 8'h04;
      RS_HRA:  oh = 8'h08;
      RS_MRB:  oh = 8'h10;
      RS_SRB:  oh = 8'h20;
      RS_CRB:  oh = 8'h40;
      RS_HRB:  oh = 8'h80;
      default: oh = 8'h00;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/duart_cs_sync.sv
// Two-flop synchronizer for one asynchronous level signal; both flops reset
// to RST_VAL so an inactive-high input never glitches active out of reset.
module duart_cs_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/duart_bus_seq.sv
// 68000 bus-cycle sequencer for the two DUART channels: register strobes,
// read-data capture, DTACK timing and inter-access recovery gap.
//
// state   | meaning
// IDLE    | waiting for synchronized chip select; latches rs/rw/write data
// STROBE  | one-cycle registered strobe to the addressed channel register
// WAIT    | DTACK_DELAY wait states; read data captured on the last one
// ACK     | dtack_n low, data driven on reads, held until chip select drops
// RECOVER | RECOVERY_CYCLES idle cycles before a new access is accepted
module duart_bus_seq
  import duart_pkg::*;
#(
  parameter int DTACK_DELAY     = 2,
  parameter int RECOVERY_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       rw,
  input  logic [3:0] rs,
  input  logic [7:0] cpu_data_in,
  input  logic [7:0] cha_rdata,
  input  logic [7:0] chb_rdata,
  output logic       dtack_n,
  output logic [7:0] cpu_data_out,
  output logic       data_oe,
  output logic       reg_rw,
  output logic [7:0] reg_wdata,
  output logic       cha_mr_cs,
  output logic       cha_sr_cs,
  output logic       cha_cr_cs,
  output logic       cha_hr_cs,
  output logic       chb_mr_cs,
  output logic       chb_sr_cs,
  output logic       chb_cr_cs,
  output logic       chb_hr_cs,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(DTACK_DELAY);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVERY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // A zero recovery count skips RECOVER entirely.
  localparam state_e EXIT_ST = (RECOVERY_CYCLES == 0) ? IDLE : RECOVER;

  logic cs_n_sync;
  logic cs_act;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       rs_q, rs_d;
  logic             rw_q, rw_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [7:0]       strobe_q, strobe_d;
  logic [7:0]       rd_mux;

  duart_cs_sync #(
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .d_i (cs_n),
    .q_o (cs_n_sync)
  );

  assign cs_act = ~cs_n_sync;

  always_comb begin
    rd_mux = 8'h00;
    if (rs_decode(rs_q) != 8'h00) begin
      rd_mux = rs_q[3] ? chb_rdata : cha_rdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rs_d     = rs_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    strobe_d = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (cs_act) begin
          rs_d     = rs;
          rw_d     = rw;
          wdata_d  = cpu_data_in;
          strobe_d = rs_decode(rs);
          state_d  = STROBE;
        end
      end
      STROBE: begin
        cnt_d   = DLY_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        // An abandoned cycle takes priority over the pending acknowledge.
        if (!cs_act) begin
          cnt_d   = REC_LOAD;
          state_d = EXIT_ST;
        end else if (cnt_q == CNT_ONE) begin
          if (rw_q) begin
            rdata_d = rd_mux;
          end
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ACK: begin
        if (!cs_act) begin
          cnt_d   = REC_LOAD;
          state_d = EXIT_ST;
        end
      end
      RECOVER: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rs_q     <= 4'h0;
      rw_q     <= 1'b1;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      strobe_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs_q     <= rs_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      strobe_q <= strobe_d;
    end
  end

  assign dtack_n      = (state_q != ACK);
  assign data_oe      = (state_q == ACK) && rw_q;
  assign busy         = (state_q != IDLE);
  assign cpu_data_out = rdata_q;
  assign reg_rw       = rw_q;
  assign reg_wdata    = wdata_q;

  assign cha_mr_cs = strobe_q[0];
  assign cha_sr_cs = strobe_q[1];
  assign cha_cr_cs = strobe_q[2];
  assign cha_hr_cs = strobe_q[3];
  assign chb_mr_cs = strobe_q[4];
  assign chb_sr_cs = strobe_q[5];
  assign chb_cr_cs = strobe_q[6];
  assign chb_hr_cs = strobe_q[7];

endmodule
